// File: rtl/dispatch_ctrl.sv
// Dispatch stage: one-entry skid buffer between rename and the reservation stations, ROB tail allocation, mispredict rewind.
// Optional DISPATCH_BYPASS_EN lets an instruction arriving at an empty buffer dispatch in the same cycle.
package types_pkg;
    localparam int FU_W = 2;

    typedef struct packed {
        logic [31:0]     pc;
        logic [FU_W-1:0] fu;
        logic [6:0]      Opcode;
        logic [5:0]      pd_new;
        logic [5:0]      ps1;
        logic [5:0]      ps2;
        logic [31:0]     imm;
        logic [2:0]      func3;
        logic [6:0]      func7;
    } rename_data;
endpackage

module dispatch_ctrl
    import types_pkg::*;
#(
    parameter int NUM_RS    = 3,
    parameter int ROB_DEPTH = 16,
    parameter int IDX_W     = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              rn_valid,
    input  rename_data        rn_data,
    output logic              rn_ready,
    input  logic [NUM_RS-1:0] rs_full,
    output logic [NUM_RS-1:0] di_en,
    output rename_data        di_data,
    output logic [IDX_W-1:0]  rob_index_out,
    input  logic              rob_full,
    output logic              rob_alloc,
    input  logic              mispredict,
    input  logic [IDX_W-1:0]  mispredict_tag
);

    typedef enum logic {EMPTY, HOLD} state_t;

    state_t           state;
    rename_data       buf_data;
    logic [IDX_W-1:0] tail;

    logic       buf_valid;
    logic       cur_valid;
    rename_data cur_data;
    logic       tgt_full;
    logic       fire;
    logic       bypass;
    logic       accept;

    function automatic logic [IDX_W-1:0] idx_inc(input logic [IDX_W-1:0] v);
        return (v == IDX_W'(ROB_DEPTH - 1)) ? '0 : v + 1'b1;
    endfunction

    assign buf_valid = (state == HOLD);

    // The candidate for dispatch is the buffered instruction; with bypass, an
    // empty buffer lets the incoming rename instruction compete directly.
    always_comb begin
`ifdef DISPATCH_BYPASS_EN
        cur_valid = buf_valid || rn_valid;
        cur_data  = buf_valid ? buf_data : rn_data;
`else
        cur_valid = buf_valid;
        cur_data  = buf_data;
`endif
        // fu codes beyond the last RS have no station and never stall on rs_full
        tgt_full = 1'b0;
        for (int i = 0; i < NUM_RS; i++)
            if (cur_data.fu == FU_W'(i)) tgt_full = rs_full[i];

        fire   = cur_valid && !tgt_full && !rob_full && !mispredict;
        bypass = fire && !buf_valid;

        di_en = '0;
        for (int i = 0; i < NUM_RS; i++)
            di_en[i] = fire && (cur_data.fu == FU_W'(i));

        rob_alloc     = fire;
        di_data       = cur_data;
        rob_index_out = tail;
        rn_ready      = !mispredict && (!buf_valid || fire);
        accept        = rn_valid && rn_ready;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= EMPTY;
            buf_data <= '0;
            tail     <= '0;
        end else if (mispredict) begin
            state <= EMPTY;
            tail  <= idx_inc(mispredict_tag);
        end else begin
            if (fire)
                tail <= idx_inc(tail);
            // a bypassed instruction is accepted and dispatched at once, so it never lands in the buffer
            if (accept && !bypass) begin
                buf_data <= rn_data;
                state    <= HOLD;
            end else if (fire) begin
                state <= EMPTY;
            end
        end
    end

endmodule

// File: tb/tb_dispatch_ctrl.sv
// Bench for dispatch_ctrl: directed scenarios with hand-derived expectations plus a randomized run against a reference model.
module tb_dispatch_ctrl;
    import types_pkg::*;

    localparam int NUM_RS    = 3;
    localparam int ROB_DEPTH = 16;
    localparam int IDX_W     = 5;
`ifdef DISPATCH_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              reset;
    logic              rn_valid;
    rename_data        rn_data;
    logic              rn_ready;
    logic [NUM_RS-1:0] rs_full;
    logic [NUM_RS-1:0] di_en;
    rename_data        di_data;
    logic [IDX_W-1:0]  rob_index_out;
    logic              rob_full;
    logic              rob_alloc;
    logic              mispredict;
    logic [IDX_W-1:0]  mispredict_tag;

    int total = 0;
    int bad   = 0;

    dispatch_ctrl #(.NUM_RS(NUM_RS), .ROB_DEPTH(ROB_DEPTH), .IDX_W(IDX_W)) dut (
        .clk(clk), .reset(reset), .rn_valid(rn_valid), .rn_data(rn_data), .rn_ready(rn_ready),
        .rs_full(rs_full), .di_en(di_en), .di_data(di_data), .rob_index_out(rob_index_out),
        .rob_full(rob_full), .rob_alloc(rob_alloc), .mispredict(mispredict),
        .mispredict_tag(mispredict_tag)
    );

    always #5 clk = ~clk;

    function automatic rename_data mk(input logic [1:0] fu);
        rename_data d;
        d.pc     = $urandom;
        d.fu     = fu;
        d.Opcode = 7'($urandom);
        d.pd_new = 6'($urandom);
        d.ps1    = 6'($urandom);
        d.ps2    = 6'($urandom);
        d.imm    = $urandom;
        d.func3  = 3'($urandom);
        d.func7  = 7'($urandom);
        return d;
    endfunction

    task automatic idle();
        rn_valid = 1'b0; rn_data = '0; rs_full = '0;
        rob_full = 1'b0; mispredict = 1'b0; mispredict_tag = '0;
    endtask

    task automatic do_reset();
        idle();
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        idle();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        total++; if (di_en !== 3'b000) begin bad++; $display("FAIL reset_di_en got=%b exp=000", di_en); end
        total++; if (rob_alloc !== 1'b0) begin bad++; $display("FAIL reset_rob_alloc got=%b exp=0", rob_alloc); end
        total++; if (rn_ready !== 1'b1) begin bad++; $display("FAIL reset_rn_ready got=%b exp=1", rn_ready); end
        total++; if (di_data !== '0) begin bad++; $display("FAIL reset_di_data got=%h exp=0", di_data); end
        total++; if (rob_index_out !== 5'd0) begin bad++; $display("FAIL reset_rob_index got=%0d exp=0", rob_index_out); end
        reset = 1'b0;
        @(negedge clk);
    endtask

    // fu 0,1,2 offered on consecutive cycles stream out one per cycle
    task automatic test_back_to_back();
        rename_data sent[3];
        logic [2:0] e_en;
        int e_idx;
        do_reset();
        for (int k = 0; k < 5; k++) begin
            rn_valid = (k < 3);
            if (k < 3) begin sent[k] = mk(2'(k)); rn_data = sent[k]; end
            else rn_data = '0;
            #1;
            if (BYP) begin e_en = (k < 3) ? 3'(1 << k) : 3'b000; e_idx = (k > 3) ? 3 : k; end
            else begin e_en = (k >= 1 && k <= 3) ? 3'(1 << (k - 1)) : 3'b000; e_idx = (k == 0) ? 0 : k - 1; end
            total++; if (di_en !== e_en) begin bad++; $display("FAIL b2b_di_en cyc=%0d got=%b exp=%b", k, di_en, e_en); end
            total++; if (rob_alloc !== (e_en != 0)) begin bad++; $display("FAIL b2b_alloc cyc=%0d got=%b exp=%b", k, rob_alloc, e_en != 0); end
            total++; if (rn_ready !== 1'b1) begin bad++; $display("FAIL b2b_rn_ready cyc=%0d got=%b exp=1", k, rn_ready); end
            total++; if (rob_index_out !== 5'(e_idx)) begin bad++; $display("FAIL b2b_rob_index cyc=%0d got=%0d exp=%0d", k, rob_index_out, e_idx); end
            if (e_en != 0) begin
                total++;
                if (di_data !== sent[BYP ? k : k - 1]) begin bad++; $display("FAIL b2b_di_data cyc=%0d got=%h exp=%h", k, di_data, sent[BYP ? k : k - 1]); end
            end
            @(negedge clk);
        end
    endtask

    // fu=2 held by rs_full[2] for 4 cycles; clears while the other RSs are full
    task automatic test_stall();
        logic [2:0] e_en;
        logic e_rdy;
        int e_idx;
        do_reset();
        for (int k = 0; k < 7; k++) begin
            rn_valid = (k == 0);
            rn_data  = (k == 0) ? mk(2'd2) : '0;
            rs_full  = (k <= 4) ? 3'b100 : (k == 5) ? 3'b011 : 3'b000;
            #1;
            e_en  = (k == 5) ? 3'b100 : 3'b000;
            e_rdy = !(k >= 1 && k <= 4);
            e_idx = (k == 6) ? 1 : 0;
            total++; if (di_en !== e_en) begin bad++; $display("FAIL stall_di_en cyc=%0d got=%b exp=%b", k, di_en, e_en); end
            total++; if (rob_alloc !== (k == 5)) begin bad++; $display("FAIL stall_alloc cyc=%0d got=%b exp=%b", k, rob_alloc, k == 5); end
            total++; if (rn_ready !== e_rdy) begin bad++; $display("FAIL stall_rn_ready cyc=%0d got=%b exp=%b", k, rn_ready, e_rdy); end
            total++; if (rob_index_out !== 5'(e_idx)) begin bad++; $display("FAIL stall_rob_index cyc=%0d got=%0d exp=%0d", k, rob_index_out, e_idx); end
            @(negedge clk);
        end
        idle();
    endtask

    // tail set to 15 by rewind, rob_full holds 2 cycles, then 15 -> 0 wrap
    task automatic test_rob_full_wrap();
        logic [2:0] e_en;
        logic e_rdy;
        int e_idx;
        do_reset();
        mispredict = 1'b1; mispredict_tag = 5'd14;
        @(negedge clk);
        idle();
        for (int k = 0; k < 6; k++) begin
            rn_valid = (k == 0 || k == 3);
            rn_data  = (k == 0) ? mk(2'd0) : (k == 3) ? mk(2'd1) : '0;
            rob_full = (k <= 2);
            #1;
            e_en  = (k == 3) ? 3'b001 : (k == 4) ? 3'b010 : 3'b000;
            e_rdy = !(k == 1 || k == 2);
            e_idx = (k <= 3) ? 15 : (k == 4) ? 0 : 1;
            total++; if (di_en !== e_en) begin bad++; $display("FAIL robfull_di_en cyc=%0d got=%b exp=%b", k, di_en, e_en); end
            total++; if (rob_alloc !== (e_en != 0)) begin bad++; $display("FAIL robfull_alloc cyc=%0d got=%b exp=%b", k, rob_alloc, e_en != 0); end
            total++; if (rn_ready !== e_rdy) begin bad++; $display("FAIL robfull_rn_ready cyc=%0d got=%b exp=%b", k, rn_ready, e_rdy); end
            total++; if (rob_index_out !== 5'(e_idx)) begin bad++; $display("FAIL robfull_rob_index cyc=%0d got=%0d exp=%0d", k, rob_index_out, e_idx); end
            @(negedge clk);
        end
        idle();
    endtask

    // rewind from tail 9 with tag 6, then tag 15 wraps; mispredict blocks accept
    task automatic test_mispredict();
        logic e_rdy;
        int e_idx;
        do_reset();
        for (int k = 0; k < 6; k++) begin
            rn_valid       = (k == 1 || k == 4);
            rn_data        = rn_valid ? mk(2'd0) : '0;
            rs_full        = (k == 1 || k == 2) ? 3'b001 : 3'b000;
            mispredict     = (k == 0 || k == 2 || k == 4);
            mispredict_tag = (k == 0) ? 5'd8 : (k == 2) ? 5'd6 : (k == 4) ? 5'd15 : 5'd0;
            #1;
            e_rdy = !mispredict;
            e_idx = (k == 0) ? 0 : (k <= 2) ? 9 : (k <= 4) ? 7 : 0;
            total++; if (di_en !== 3'b000) begin bad++; $display("FAIL misp_di_en cyc=%0d got=%b exp=000", k, di_en); end
            total++; if (rob_alloc !== 1'b0) begin bad++; $display("FAIL misp_alloc cyc=%0d got=%b exp=0", k, rob_alloc); end
            total++; if (rn_ready !== e_rdy) begin bad++; $display("FAIL misp_rn_ready cyc=%0d got=%b exp=%b", k, rn_ready, e_rdy); end
            total++; if (rob_index_out !== 5'(e_idx)) begin bad++; $display("FAIL misp_rob_index cyc=%0d got=%0d exp=%0d", k, rob_index_out, e_idx); end
            @(negedge clk);
        end
        idle();
    endtask

    // fu=3 has no station: allocates a ROB entry, ignores rs_full, no strobe
    task automatic test_nop();
        logic e_alloc;
        int e_idx;
        do_reset();
        for (int k = 0; k < 3; k++) begin
            rs_full  = 3'b111;
            rn_valid = (k == 0);
            rn_data  = (k == 0) ? mk(2'd3) : '0;
            #1;
            e_alloc = BYP ? (k == 0) : (k == 1);
            e_idx   = BYP ? ((k == 0) ? 0 : 1) : ((k <= 1) ? 0 : 1);
            total++; if (di_en !== 3'b000) begin bad++; $display("FAIL nop_di_en cyc=%0d got=%b exp=000", k, di_en); end
            total++; if (rob_alloc !== e_alloc) begin bad++; $display("FAIL nop_alloc cyc=%0d got=%b exp=%b", k, rob_alloc, e_alloc); end
            total++; if (rob_index_out !== 5'(e_idx)) begin bad++; $display("FAIL nop_rob_index cyc=%0d got=%0d exp=%0d", k, rob_index_out, e_idx); end
            @(negedge clk);
        end
        idle();
    endtask

    // reset during a stall drops the buffered instruction
    task automatic test_reset_midstall();
        do_reset();
        rn_valid = 1'b1; rn_data = mk(2'd2); rs_full = 3'b100;
        @(negedge clk);
        rn_valid = 1'b0; rn_data = '0;
        #1;
        total++; if (rn_ready !== 1'b0) begin bad++; $display("FAIL midstall_held got=%b exp=0", rn_ready); end
        @(negedge clk);
        reset = 1'b1;
        #1;
        reset = 1'b0;
        rs_full = 3'b000;
        #1;
        for (int k = 0; k < 2; k++) begin
            total++; if (di_en !== 3'b000) begin bad++; $display("FAIL midstall_di_en cyc=%0d got=%b exp=000", k, di_en); end
            total++; if (rob_alloc !== 1'b0) begin bad++; $display("FAIL midstall_alloc cyc=%0d got=%b exp=0", k, rob_alloc); end
            total++; if (rn_ready !== 1'b1) begin bad++; $display("FAIL midstall_rn_ready cyc=%0d got=%b exp=1", k, rn_ready); end
            @(negedge clk);
            #1;
        end
        @(negedge clk);
        idle();
    endtask

    // Reference model: an optional pending instruction and a tail counter mod ROB_DEPTH.
    task automatic test_random();
        bit         m_valid;
        rename_data m_data;
        int         m_tail;
        rename_data cand;
        bit         has, f, er;
        logic [2:0] ee;
        do_reset();
        m_valid = 1'b0; m_data = '0; m_tail = 0;
        for (int k = 0; k < 400; k++) begin
            rn_valid       = ($urandom % 4) != 0;
            rn_data        = mk(2'($urandom % 4));
            rs_full        = ($urandom % 3 == 0) ? 3'($urandom) : 3'b000;
            rob_full       = ($urandom % 8) == 0;
            mispredict     = ($urandom % 16) == 0;
            mispredict_tag = 5'($urandom % ROB_DEPTH);
            #1;
            has  = m_valid || (BYP && rn_valid);
            cand = m_valid ? m_data : rn_data;
            f    = has && (cand.fu >= 2'(NUM_RS) || !rs_full[cand.fu]) && !rob_full && !mispredict;
            ee   = (f && cand.fu < 2'(NUM_RS)) ? 3'(1 << cand.fu) : 3'b000;
            er   = !mispredict && (!m_valid || f);
            total++; if (di_en !== ee) begin bad++; $display("FAIL rand_di_en cyc=%0d got=%b exp=%b", k, di_en, ee); end
            total++; if (rob_alloc !== f) begin bad++; $display("FAIL rand_alloc cyc=%0d got=%b exp=%b", k, rob_alloc, f); end
            total++; if (rn_ready !== er) begin bad++; $display("FAIL rand_rn_ready cyc=%0d got=%b exp=%b", k, rn_ready, er); end
            total++; if (rob_index_out !== 5'(m_tail)) begin bad++; $display("FAIL rand_rob_index cyc=%0d got=%0d exp=%0d", k, rob_index_out, m_tail); end
            if (f) begin
                total++; if (di_data !== cand) begin bad++; $display("FAIL rand_di_data cyc=%0d got=%h exp=%h", k, di_data, cand); end
            end
            if (mispredict) begin
                m_valid = 1'b0;
                m_tail  = (int'(mispredict_tag) + 1) % ROB_DEPTH;
            end else begin
                if (f) m_tail = (m_tail + 1) % ROB_DEPTH;
                if (rn_valid && er) begin
                    if (!(f && !m_valid)) begin m_valid = 1'b1; m_data = rn_data; end
                end else if (f) begin
                    m_valid = 1'b0;
                end
            end
            @(negedge clk);
        end
        idle();
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_stall();
        test_rob_full_wrap();
        test_mispredict();
        test_nop();
        test_reset_midstall();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/dispatch_ctrl.md
Name: dispatch_ctrl

Overview:
- Sits between the rename stage and the per-FU reservation stations.
- Buffers one renamed instruction and steers it by its fu field to exactly one RS via a one-hot di_en.
- Allocates the ROB index for each dispatched instruction, stalls rename on RS-full or ROB-full, and flushes/rewinds on mispredict.

Parameters:
- NUM_RS, 3, number of reservation stations; fu codes 0..NUM_RS-1 (0=ALU, 1=BRANCH, 2=LSU).
- ROB_DEPTH, 16, ROB entries; index wraps ROB_DEPTH-1 -> 0.
- IDX_W, 5, ROB index width.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- rn_valid  in  1  rename has a valid instruction
- rn_data  in  rename_data  renamed instruction (pc, fu, Opcode, pd_new, ps1, ps2, imm, func3, func7)
- rn_ready  out  1  dispatch accepts rn_data this cycle
- rs_full  in  NUM_RS  per-RS full flag
- di_en  out  NUM_RS  one-hot dispatch strobe to the target RS
- di_data  out  rename_data  instruction presented to all RSs
- rob_index_out  out  IDX_W  ROB index assigned to di_data
- rob_full  in  1  ROB cannot allocate
- rob_alloc  out  1  ROB allocation strobe, equals "fire"
- mispredict  in  1  flush request
- mispredict_tag  in  IDX_W  ROB index of the mispredicted branch

Behaviour:
- State is a one-entry buffer (buf_valid, buf_data) plus tail register tail[IDX_W-1:0]. States: EMPTY (buf_valid=0) and HOLD (buf_valid=1).
- Reset: buf_valid=0, buf_data='0, tail=0. Outputs at reset: di_en=0, rob_alloc=0, rn_ready=1, di_data='0, rob_index_out=0.
- sel = buf_data.fu. tgt_ok = (sel>=NUM_RS) || !rs_full[sel].
- fire = buf_valid && tgt_ok && !rob_full && !mispredict.
- Outputs are combinational from registered state and inputs:
  - di_en[sel] = fire && sel<NUM_RS; all other bits 0.
  - rob_alloc = fire.
  - di_data = buf_data.
  - rob_index_out = tail.
- rn_ready = !mispredict && (!buf_valid || fire).
- Accept = rn_valid && rn_ready: buf_data<=rn_data, buf_valid<=1.
- Fire without accept: buf_valid<=0.
- Fire and accept in the same cycle: buffer reloads with the new instruction. This gives back-to-back throughput of 1 per cycle.
- On fire: tail <= (tail==ROB_DEPTH-1) ? 0 : tail+1.
- fu >= NUM_RS (system/NOP class): consumes a ROB entry (rob_alloc=1), asserts no di_en.
- Latency: rename accept to di_en is 1 cycle minimum.
- Stall: buffer and tail are held unchanged while the target RS is full or the ROB is full. Stall on rs_full[sel] is independent of the other RSs; no reordering.
- Mispredict has priority over all other events in its cycle:
  - buf_valid<=0.
  - tail <= (mispredict_tag==ROB_DEPTH-1) ? 0 : mispredict_tag+1.
  - di_en=0, rob_alloc=0, rn_ready=0; no accept.
- Reset mid-stall discards the buffered instruction; no strobe is emitted.
- rename_data width and field layout are taken from types_pkg unchanged.

Optional Feature:
DISPATCH_BYPASS_EN
- Defined: when buf_valid=0, rn_valid=1, the rn_data target is not full, !rob_full and !mispredict, rn_data fires in the same cycle:
  - di_data=rn_data, di_en[rn_data.fu]=1, rob_alloc=1, tail advances.
  - Buffer stays EMPTY. Latency is 0 cycles.
  - If the bypass cannot fire, the accept goes into the buffer as normal.
- Undefined: no combinational path from rn_* to di_*; latency is always >=1 cycle.

Test Plan:
- Reset, then 3 instructions with fu=0,1,2 and no fulls -> di_en = 001, 010, 100 on consecutive cycles; rob_index_out = 0, 1, 2; rn_ready stays 1.
- Buffer holds fu=2 with rs_full=3'b100 for 4 cycles -> di_en=0, rob_alloc=0, rn_ready=0 for 4 cycles. The cycle rs_full clears -> di_en=100, tail advances by exactly 1.
- tail=15 at fire -> rob_index_out=15, then next fire shows 0. rob_full=1 for 2 cycles -> no alloc, tail held.
- Buffer valid, tail=9, mispredict=1 with mispredict_tag=6 -> di_en=0 that cycle; next cycle buf_valid=0 and rob_index_out=7. mispredict_tag=15 -> rob_index_out=0.
- Instruction with fu=3 (NUM_RS=3) -> rob_alloc=1, di_en=000, tail+1.
- With DISPATCH_BYPASS_EN, empty buffer and rn_valid with fu=1 -> di_en=010 in the same cycle. Without the macro -> di_en=010 one cycle later.
